// File: rtl/iq_lockin_decimator.sv
// Multi-channel square-wave I/Q lock-in demodulator with integrate-and-dump and a valid/ready word serialiser.
// Optional `IQ_ROUND_EN: round half up before the output shift (default build truncates).
module iq_lockin_decimator #(
  parameter int N_CH    = 2,
  parameter int DATA_W  = 14,
  parameter int PHASE_W = 32,
  parameter int DECIM   = 1024,
  parameter int ACC_W   = 26,
  parameter int SHIFT   = 10,
  parameter int OUT_W   = 14
) (
  input  logic                      CLK,
  input  logic                      reset_n,
  input  logic signed [DATA_W-1:0]  sample_in,
  input  logic                      sample_valid,
  input  logic [N_CH*PHASE_W-1:0]   phase_inc,
  input  logic                      sync_clear,
  output logic signed [OUT_W-1:0]   out_data,
  output logic [2:0]                out_ch,
  output logic                      out_q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      frame_done,
  output logic                      overrun
);

  localparam int N_WORDS = 2 * N_CH;
  localparam int CNT_W   = $clog2(DECIM);
  localparam int IDX_W   = $clog2(N_WORDS);

  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((64'd1 << (OUT_W-1)) - 64'd1);
  localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;
`ifdef IQ_ROUND_EN
  localparam logic signed [ACC_W:0] RND =
    (SHIFT > 0) ? (ACC_W+1)'(64'd1 << ((SHIFT > 0) ? SHIFT-1 : 0)) : '0;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               overrun_q, overrun_d;
  logic               frame_done_q;

  logic               step, dump, last_xfer, accept;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [OUT_W-1:0] shadow_w [N_WORDS];

  function automatic logic signed [OUT_W-1:0] scale(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] v;
    r = {a[ACC_W-1], a};
`ifdef IQ_ROUND_EN
    r = r + RND;
`endif
    v = r >>> SHIFT;
    if (v > SAT_HI)      return SAT_HI[OUT_W-1:0];
    else if (v < SAT_LO) return SAT_LO[OUT_W-1:0];
    else                 return v[OUT_W-1:0];
  endfunction

  // sync_clear discards a coincident sample, so it also suppresses that cycle's dump.
  assign step       = sample_valid && !sync_clear;
  assign dump       = step && (cnt_q == CNT_W'(DECIM-1));
  assign last_xfer  = (state_q == SEND) && out_ready && (idx_q == IDX_W'(N_WORDS-1));
  assign accept     = dump && ((state_q == IDLE) || last_xfer);
  assign sample_ext = {{(ACC_W-DATA_W){sample_in[DATA_W-1]}}, sample_in};

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [PHASE_W-1:0]      phase_q, phase_d;
      logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
      logic signed [ACC_W-1:0] sum_i, sum_q;
      logic signed [OUT_W-1:0] shadow_i_q, shadow_q_q;
      logic                    q_neg;

      // MSB of (phase + quarter turn): the carry out of bit PHASE_W-2 flips the MSB.
      assign q_neg = phase_q[PHASE_W-1] ^ phase_q[PHASE_W-2];
      assign sum_i = acc_i_q + (phase_q[PHASE_W-1] ? -sample_ext : sample_ext);
      assign sum_q = acc_q_q + (q_neg ? -sample_ext : sample_ext);

      always_comb begin
        phase_d = phase_q;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        if (sync_clear) begin
          phase_d = '0;
          acc_i_d = '0;
          acc_q_d = '0;
        end else if (sample_valid) begin
          phase_d = phase_q + phase_inc[gi*PHASE_W +: PHASE_W];
          acc_i_d = dump ? '0 : sum_i;
          acc_q_d = dump ? '0 : sum_q;
        end
      end

      always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
          phase_q    <= '0;
          acc_i_q    <= '0;
          acc_q_q    <= '0;
          shadow_i_q <= '0;
          shadow_q_q <= '0;
        end else begin
          phase_q <= phase_d;
          acc_i_q <= acc_i_d;
          acc_q_q <= acc_q_d;
          if (accept) begin
            shadow_i_q <= scale(sum_i);
            shadow_q_q <= scale(sum_q);
          end
        end
      end

      assign shadow_w[2*gi]   = shadow_i_q;
      assign shadow_w[2*gi+1] = shadow_q_q;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == IDX_W'(N_WORDS-1)) begin
            idx_d   = '0;
            state_d = accept ? SEND : IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sync_clear)        cnt_d = '0;
    else if (sample_valid) cnt_d = dump ? '0 : cnt_q + CNT_W'(1);
    overrun_d = overrun_q;
    if (sync_clear)               overrun_d = 1'b0;
    else if (dump && !accept)     overrun_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      overrun_q    <= overrun_d;
      frame_done_q <= accept;
    end
  end

  assign out_valid  = (state_q == SEND);
  assign out_data   = out_valid ? shadow_w[idx_q] : '0;
  assign out_ch     = out_valid ? 3'(idx_q >> 1) : 3'd0;
  assign out_q      = out_valid & idx_q[0];
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_iq_lockin_decimator.sv
// Randomised, model-checked bench for iq_lockin_decimator (N_CH=2, DECIM=4, SHIFT=0).
module tb_iq_lockin_decimator;

  localparam int N_CH = 2, DATA_W = 14, PHASE_W = 32, DECIM = 4, ACC_W = 26, SHIFT = 0, OUT_W = 14;

  logic                    CLK = 1'b0;
  logic                    reset_n = 1'b0;
  logic [DATA_W-1:0]       sample_in = '0;
  logic                    sample_valid = 1'b0;
  logic [N_CH*PHASE_W-1:0] phase_inc = '0;
  logic                    sync_clear = 1'b0;
  logic [OUT_W-1:0]        out_data;
  logic [2:0]              out_ch;
  logic                    out_q, out_valid, frame_done, overrun;
  logic                    out_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  iq_lockin_decimator #(.N_CH(N_CH), .DATA_W(DATA_W), .PHASE_W(PHASE_W), .DECIM(DECIM),
                        .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
    .CLK(CLK), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .phase_inc(phase_inc), .sync_clear(sync_clear), .out_data(out_data), .out_ch(out_ch),
    .out_q(out_q), .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done),
    .overrun(overrun));

  always #5 CLK = ~CLK;

  // Observed transfers, sampled on the falling edge.
  logic [17:0] obs_q[$];
  int          obs_cyc[$];
  int          cyc = 0;
  int          fd_count = 0;

  always @(negedge CLK) begin
    cyc++;
    if (frame_done) fd_count++;
    if (out_valid && out_ready) begin
      obs_q.push_back({out_ch, out_q, out_data});
      obs_cyc.push_back(cyc);
    end
  end

  // Reference model: plain per-frame sums of sample * (+/-1) references.
  int unsigned m_phase[N_CH];
  logic [31:0] m_inc[N_CH];
  longint      m_acc_i[N_CH], m_acc_q[N_CH];
  int          m_cnt = 0;
  logic [17:0] exp_q[$];

  function automatic logic [17:0] mk(int ch, int q, longint d);
    return {3'(ch), 1'(q), 14'(d)};
  endfunction

  function automatic longint model_scale(longint a);
    longint v = a;
`ifdef IQ_ROUND_EN
    if (SHIFT > 0) v += (64'sd1 <<< ((SHIFT > 0) ? SHIFT-1 : 0));
`endif
    v = v >>> SHIFT;
    if (v > 8191) v = 8191;
    if (v < -8192) v = -8192;
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N_CH; k++) begin
      m_phase[k] = 0; m_acc_i[k] = 0; m_acc_q[k] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_sample(int s);
    for (int k = 0; k < N_CH; k++) begin
      int unsigned qp = m_phase[k] + 32'h4000_0000;
      m_acc_i[k] += m_phase[k][31] ? -s : s;
      m_acc_q[k] += qp[31] ? -s : s;
      m_phase[k] += m_inc[k];
    end
    m_cnt++;
    if (m_cnt == DECIM) begin
      for (int k = 0; k < N_CH; k++) begin
        exp_q.push_back(mk(k, 0, model_scale(m_acc_i[k])));
        exp_q.push_back(mk(k, 1, model_scale(m_acc_q[k])));
        m_acc_i[k] = 0; m_acc_q[k] = 0;
      end
      m_cnt = 0;
    end
  endtask

  task automatic step(input logic v, input int s, input logic c);
    sample_valid = v;
    sample_in    = 14'(s);
    sync_clear   = c;
    phase_inc    = {m_inc[1], m_inc[0]};
    if (c) model_clear();
    else if (v) model_sample(s);
    @(posedge CLK); #1;
    sample_valid = 1'b0;
    sync_clear   = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  task automatic prep(input logic [31:0] inc0, input logic [31:0] inc1);
    out_ready = 1'b1;
    idle(10);
    m_inc[0] = inc0; m_inc[1] = inc1;
    step(1'b0, 0, 1'b1);
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    fd_count = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1 reset_n = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (out_data !== '0 || out_ch !== 3'd0 || out_q !== 1'b0) begin
      n_errors++; $display("FAIL reset_data: got %h/%0d/%b expected 0/0/0", out_data, out_ch, out_q);
    end
    n_checks++;
    if (overrun !== 1'b0 || frame_done !== 1'b0) begin
      n_errors++; $display("FAIL reset_flags: got ovr=%b fd=%b expected 0/0", overrun, frame_done);
    end
  endtask

  task automatic test_quadrature();
    int vals[4] = '{100, 100, -100, -100};
    prep(32'h4000_0000, 32'h8000_0000);
    foreach (vals[i]) step(1'b1, vals[i], 1'b0);
    idle(6);
    n_checks++;
    if (obs_q.size() !== 4 || exp_q.size() !== 4) begin
      n_errors++; $display("FAIL quad_count: got %0d words expected 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL quad_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
      n_checks++;
      if (obs_q[0] !== mk(0, 0, 400) || obs_q[1] !== mk(0, 1, 0)) begin
        n_errors++; $display("FAIL quad_ch0: got %h %h expected %h %h", obs_q[0], obs_q[1], mk(0, 0, 400), mk(0, 1, 0));
      end
    end
    n_checks++;
    if (fd_count !== 1) begin n_errors++; $display("FAIL quad_frame_done: got %0d pulses expected 1", fd_count); end
  endtask

  task automatic test_saturation();
    int levels[2] = '{8191, -8192};
    foreach (levels[j]) begin
      prep(32'd0, 32'd0);
      repeat (4) step(1'b1, levels[j], 1'b0);
      idle(6);
      n_checks++;
      if (obs_q.size() !== 4) begin
        n_errors++; $display("FAIL sat_count%0d: got %0d words expected 4", j, obs_q.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          n_checks++;
          if (obs_q[i] !== mk(i/2, i%2, levels[j]) || obs_q[i] !== exp_q[i]) begin
            n_errors++; $display("FAIL sat_word%0d_%0d: got %h expected %h", j, i, obs_q[i], mk(i/2, i%2, levels[j]));
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    prep(32'd0, 32'd0);
    out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 5, 1'b0);
      if (i >= 4) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 14'd20 || out_ch !== 3'd0 || out_q !== 1'b0) begin
          n_errors++; $display("FAIL bp_hold%0d: got v=%b d=%0d ch=%0d q=%b expected 1/20/0/0", i, out_valid, out_data, out_ch, out_q);
        end
      end
      if (i == 7 || i == 8) begin
        n_checks++;
        if (overrun !== (i == 8)) begin n_errors++; $display("FAIL bp_overrun%0d: got %b expected %b", i, overrun, i == 8); end
      end
    end
    out_ready = 1'b1;
    idle(8);
    n_checks++;
    if (obs_q.size() !== 4) begin
      n_errors++; $display("FAIL bp_count: got %0d words expected 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_q[i] !== mk(i/2, i%2, 20)) begin n_errors++; $display("FAIL bp_word%0d: got %h expected %h", i, obs_q[i], mk(i/2, i%2, 20)); end
      end
    end
    n_checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      n_errors++; $display("FAIL bp_after: got v=%b ovr=%b expected 0/1", out_valid, overrun);
    end
    step(1'b0, 0, 1'b1);
    n_checks++;
    if (overrun !== 1'b0) begin n_errors++; $display("FAIL bp_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_back_to_back();
    prep($urandom, $urandom);
    for (int i = 0; i < 8; i++) step(1'b1, int'($urandom_range(0, 8000)) - 4000, 1'b0);
    idle(6);
    n_checks++;
    if (obs_q.size() !== 8 || exp_q.size() !== 8) begin
      n_errors++; $display("FAIL b2b_count: got %0d words expected 8", obs_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i] || obs_cyc[i] !== obs_cyc[0] + i) begin
          n_errors++; $display("FAIL b2b_word%0d: got %h at cycle +%0d expected %h at +%0d", i, obs_q[i], obs_cyc[i] - obs_cyc[0], exp_q[i], i);
        end
      end
    end
    n_checks++;
    if (overrun !== 1'b0 || fd_count !== 2) begin
      n_errors++; $display("FAIL b2b_flags: got ovr=%b fd=%0d expected 0/2", overrun, fd_count);
    end
  endtask

  task automatic test_sync_clear();
    prep(32'd0, 32'd0);
    step(1'b1, 10, 1'b0);
    step(1'b1, 10, 1'b0);
    step(1'b1, 10, 1'b1);
    repeat (4) step(1'b1, 10, 1'b0);
    idle(6);
    n_checks++;
    if (obs_q.size() !== 4 || fd_count !== 1) begin
      n_errors++; $display("FAIL sc_count: got %0d words %0d frames expected 4/1", obs_q.size(), fd_count);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_q[i] !== mk(i/2, i%2, 40) || obs_q[i] !== exp_q[i]) begin
          n_errors++; $display("FAIL sc_word%0d: got %h expected %h", i, obs_q[i], mk(i/2, i%2, 40));
        end
      end
    end
  endtask

  task automatic test_random();
    int nexp;
    prep($urandom, $urandom);
    for (int i = 0; i < 80; i++) begin
      if (i == 40) begin m_inc[0] = $urandom; m_inc[1] = $urandom; end
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 4000)) - 2000, 1'b0);
    end
    for (int i = 0; i < DECIM && m_cnt != 0; i++) step(1'b1, int'($urandom_range(0, 4000)) - 2000, 1'b0);
    idle(6);
    nexp = exp_q.size();
    n_checks++;
    if (obs_q.size() !== nexp || fd_count !== nexp / 4) begin
      n_errors++; $display("FAIL rnd_count: got %0d words %0d frames expected %0d/%0d", obs_q.size(), fd_count, nexp, nexp / 4);
    end else begin
      for (int i = 0; i < nexp; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL rnd_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
    end
    n_checks++;
    if (overrun !== 1'b0) begin n_errors++; $display("FAIL rnd_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_async_reset();
    prep(32'd0, 32'd0);
    out_ready = 1'b0;
    repeat (4) step(1'b1, 7, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL ar_presend: got %b expected 1", out_valid); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_errors++; $display("FAIL ar_drop: got v=%b d=%0d expected 0/0", out_valid, out_data);
    end
    @(posedge CLK); #1 reset_n = 1'b1;
    model_clear();
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 7, 1'b0);
      n_checks++;
      if (out_valid !== (i == 4) || (i == 4 && out_data !== 14'd28)) begin
        n_errors++; $display("FAIL ar_sample%0d: got v=%b d=%0d expected %b/28", i, out_valid, out_data, i == 4);
      end
    end
    out_ready = 1'b1;
    idle(6);
    n_checks++;
    if (obs_q.size() !== 4 || overrun !== 1'b0) begin
      n_errors++; $display("FAIL ar_after: got %0d words ovr=%b expected 4/0", obs_q.size(), overrun);
    end
  endtask

  initial begin
    m_inc[0] = '0; m_inc[1] = '0;
    model_clear();
    test_reset();
    test_quadrature();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_sync_clear();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iq_lockin_decimator.md
Name: iq_lockin_decimator

Overview:
- Parametrised multi-channel square-wave lock-in demodulator. Successor to the single-channel fixed-frequency IQ stage.
- Each channel runs its own phase accumulator. It mixes the shared signed ADC sample stream with ±1 I/Q references, then integrates and dumps over DECIM samples.
- Each frame's 2*N_CH results are serialised over a valid/ready stream to the DAC/display muxing logic.

Parameters:
N_CH, 2, number of independent demodulation channels (1..8)
DATA_W, 14, signed input sample width
PHASE_W, 32, phase accumulator width per channel
DECIM, 1024, valid samples per integrate-and-dump frame (>=2)
ACC_W, 26, signed integrator width; must be >= DATA_W+clog2(DECIM)+1
SHIFT, 10, arithmetic right shift applied to each integrator result before output
OUT_W, 14, signed output width; the shifted result saturates to this width

Ports:
CLK  input  1  system clock (50 MHz)
reset_n  input  1  asynchronous active-low reset
sample_in  input  DATA_W  signed ADC sample
sample_valid  input  1  sample_in is valid this cycle
phase_inc  input  N_CH*PHASE_W  per-channel phase increments; channel k occupies bits [k*PHASE_W +: PHASE_W]
sync_clear  input  1  one-cycle pulse: restart phases and the current frame
out_data  output  OUT_W  signed demodulated result
out_ch  output  3  channel index of out_data
out_q  output  1  0 = I component, 1 = Q component
out_valid  output  1  out_data, out_ch and out_q are valid
out_ready  input  1  consumer accepts the word
frame_done  output  1  one-cycle pulse when a frame is snapshotted
overrun  output  1  sticky flag: a frame was dropped

Behaviour:
- Reset (async assert, sync release): all phase accumulators, integrators and the sample counter go to 0. FSM goes to IDLE. All outputs are 0.
- Per sample_valid cycle, for each channel k:
  - phase_k <= phase_k + inc_k (wraps mod 2^PHASE_W).
  - Mixing uses the phase value before the increment.
  - I reference is +1 if phase_k[MSB]==0, else -1.
  - Q reference is +1 if (phase_k + 2^(PHASE_W-2))[MSB]==0, else -1.
  - Each product is sample_in sign-extended to ACC_W, then negated or not. -2^(DATA_W-1) negates without overflow at ACC_W.
  - Integrators add the products; no wrap is possible within the ACC_W rule.
- The sample counter counts 0..DECIM-1. On the valid sample where the count equals DECIM-1:
  - Integrator values including that sample are copied to the 2*N_CH shadow buffer.
  - Integrators clear to 0 and the counter wraps to 0.
  - frame_done pulses on the next cycle.
- Output scaling per word:
  - v = integrator >>> SHIFT (arithmetic).
  - Clamp v to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Serialiser FSM, states IDLE and SEND:
  - IDLE -> SEND on a snapshot. out_valid rises the cycle after the dump sample (latency 1).
  - Word order: ch0 I, ch0 Q, ch1 I, ch1 Q, ... , ch(N_CH-1) Q.
  - A word transfers when out_valid && out_ready. out_data, out_ch and out_q stay stable while out_valid && !out_ready.
  - After the last word transfers: SEND -> IDLE and out_valid falls on the next cycle, unless a snapshot is pending.
- Snapshot while in SEND, including the cycle of the final word's transfer:
  - If the final word transfers in that same cycle, the new snapshot is accepted and SEND restarts at ch0 I with no idle cycle.
  - Otherwise the new frame is dropped, the shadow buffer is untouched and overrun is set.
- overrun clears only on reset or sync_clear.
- sync_clear:
  - Zeroes phases, integrators and the counter, and clears overrun.
  - A sample_valid in the same cycle is discarded (clear wins).
  - An in-progress SEND completes unaffected.
- phase_inc is sampled every valid cycle. A change takes effect on the next increment, without a phase jump.
- Reset asserted mid-SEND drops out_valid immediately (asynchronously).

Optional Feature:
- Macro: IQ_ROUND_EN.
- Defined: add 2^(SHIFT-1) before the shift (round half up), then saturate. When SHIFT==0 the rounding term is 0.
- Undefined: plain truncating arithmetic shift.

Test Plan:
- Quadrature detection: N_CH=1, DECIM=4, SHIFT=0, inc=2^30, input +100,+100,-100,-100 -> words I=400 then Q=0; frame_done pulses once.
- Saturation: N_CH=1, DECIM=4, SHIFT=0, inc=0, input constant 8191 -> I=8191, Q=8191 (clamped from 32764). Input constant -8192 -> I=Q=-8192.
- Backpressure and overrun: N_CH=2, DECIM=4, SHIFT=0, inc=0, input constant +5, out_ready=0 for 12 samples -> out_valid held with ch0 I=20; overrun=1 after sample 8. Then ready=1 -> exactly 4 words, all 20, in the order (0,I),(0,Q),(1,I),(1,Q).
- Back-to-back frames: ready=1 always, DECIM=4, N_CH=2 -> the 8th sample's dump coincides with the last transfer; SEND restarts at ch0 I with no IDLE gap and overrun stays 0.
- sync_clear: pulse after 2 valid samples of +10 (DECIM=4, inc=0), asserted together with a valid sample -> next frame is built from the 4 subsequent samples only, giving I=40.
- Async reset mid-SEND: assert reset_n=0 between clock edges -> out_valid=0 at once; after release, the first words appear only after DECIM new valid samples.
